// File: rtl/fifo_2entry.sv
// fifo_2entry
//   Two-entry in-order buffer used for each output port of demux_1to2_buf.
//   Words are stored in a two-slot ring addressed by one-bit read/write
//   pointers. Occupancy is kept in a registered counter so that full/empty
//   and the count output come straight from flops.
//
// Ports
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : asynchronous active-high reset, empties the buffer
//   push   : write din at the tail (ignored while full)
//   pop    : remove the head word (ignored while empty)
//   din    : word to be written
//   dout   : head word, meaningful only while empty = 0
//   count  : current occupancy, 0..2
//   full   : count == 2
//   empty  : count == 0
module fifo_2entry #(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push,
   input  logic            pop,
   input  logic [size-1:0] din,
   output logic [size-1:0] dout,
   output logic [1:0]      count,
   output logic            full,
   output logic            empty
);

   localparam int         DEPTH      = 2;
   localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

   logic [size-1:0] mem [DEPTH];
   logic            wr_ptr;
   logic            rd_ptr;
   logic            do_push;
   logic            do_pop;

   // A push into a full buffer is refused even if a pop happens in the same
   // cycle; the freed slot only becomes usable on the following cycle.
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == 2'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy state. With only two slots, advancing a pointer
   // is a toggle. A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left out of reset: its contents are never
   // observed while the buffer reports empty.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf
//   Routes an upstream valid/ready stream to one of two buffered output
//   ports chosen per word by select_i. Each port has its own two-entry
//   buffer, so a stalled consumer on one port never blocks the other.
//
// Ports
//   clk_i, rst_i       : clock and asynchronous active-high reset
//   data_i, valid_i    : upstream word and its valid flag
//   select_i           : destination port of data_i (0 or 1)
//   ready_o            : addressed buffer has room this cycle
//   data0_o, valid0_o  : port 0 head word and non-empty flag
//   ready0_i           : port 0 consumer takes the head word
//   data1_o, valid1_o  : port 1 head word and non-empty flag
//   ready1_i           : port 1 consumer takes the head word
//   count0_o, count1_o : registered occupancy of each port buffer
module demux_1to2_buf #(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [size-1:0] data_i,
   input  logic            valid_i,
   input  logic            select_i,
   output logic            ready_o,
   output logic [size-1:0] data0_o,
   output logic            valid0_o,
   input  logic            ready0_i,
   output logic [size-1:0] data1_o,
   output logic            valid1_o,
   input  logic            ready1_i,
   output logic [1:0]      count0_o,
   output logic [1:0]      count1_o
);

   logic full0;
   logic full1;
   logic empty0;
   logic empty1;
   logic push0;
   logic push1;

   // ready_o depends only on select_i and the addressed buffer's full flag,
   // never on the downstream ready inputs.
   assign ready_o  = select_i ? !full1 : !full0;
   assign push0    = valid_i && !select_i && ready_o;
   assign push1    = valid_i &&  select_i && ready_o;
   assign valid0_o = !empty0;
   assign valid1_o = !empty1;

   fifo_2entry #(.size(size)) u_fifo0 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push0),
      .pop   (ready0_i),
      .din   (data_i),
      .dout  (data0_o),
      .count (count0_o),
      .full  (full0),
      .empty (empty0)
   );

   fifo_2entry #(.size(size)) u_fifo1 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push1),
      .pop   (ready1_i),
      .din   (data_i),
      .dout  (data1_o),
      .count (count1_o),
      .full  (full1),
      .empty (empty1)
   );

endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb_demux_1to2_buf
//   Drives directed scenarios followed by random traffic into
//   demux_1to2_buf and compares every output against a queue-based model
//   of two independent two-word in-order buffers.
module tb_demux_1to2_buf;

   localparam int SIZE = 32;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [SIZE-1:0] data_i;
   logic            valid_i;
   logic            select_i;
   logic            ready_o;
   logic [SIZE-1:0] data0_o;
   logic            valid0_o;
   logic            ready0_i;
   logic [SIZE-1:0] data1_o;
   logic            valid1_o;
   logic            ready1_i;
   logic [1:0]      count0_o;
   logic [1:0]      count1_o;

   int checks   = 0;
   int failures = 0;

   logic [SIZE-1:0] q0[$];
   logic [SIZE-1:0] q1[$];

   demux_1to2_buf #(.size(SIZE)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .data_i   (data_i),
      .valid_i  (valid_i),
      .select_i (select_i),
      .ready_o  (ready_o),
      .data0_o  (data0_o),
      .valid0_o (valid0_o),
      .ready0_i (ready0_i),
      .data1_o  (data1_o),
      .valid1_o (valid1_o),
      .ready1_i (ready1_i),
      .count0_o (count0_o),
      .count1_o (count1_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [SIZE-1:0] observed,
                              input logic [SIZE-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, observed, expected, $time);
      end
   endtask

   // Compare the current outputs with the model's view of both buffers.
   task automatic checkAll(input string tag, input logic sel);
      int      room;
      checkOutput({tag, ".ready_o"}, SIZE'(ready_o),
                  SIZE'(sel ? (q1.size() < 2) : (q0.size() < 2)));
      checkOutput({tag, ".valid0"}, SIZE'(valid0_o), SIZE'(q0.size() > 0));
      checkOutput({tag, ".valid1"}, SIZE'(valid1_o), SIZE'(q1.size() > 0));
      checkOutput({tag, ".count0"}, SIZE'(count0_o), SIZE'(q0.size()));
      checkOutput({tag, ".count1"}, SIZE'(count1_o), SIZE'(q1.size()));
      if (q0.size() > 0) checkOutput({tag, ".data0"}, data0_o, q0[0]);
      if (q1.size() > 0) checkOutput({tag, ".data1"}, data1_o, q1[0]);
      room = 0;
   endtask

   // One clock cycle: drive inputs, check mid-cycle, then advance the model
   // across the rising edge. Pops and the push decision use pre-edge
   // occupancy, so a full buffer refuses a push even when it is popped.
   task automatic applyStimulus(input string tag, input logic v, input logic sel,
                                input logic [SIZE-1:0] d, input logic r0, input logic r1);
      bit acc;
      bit p0;
      bit p1;
      valid_i  = v;
      select_i = sel;
      data_i   = d;
      ready0_i = r0;
      ready1_i = r1;
      #4;
      checkAll(tag, sel);
      acc = v && (sel ? (q1.size() < 2) : (q0.size() < 2));
      p0  = r0 && (q0.size() > 0);
      p1  = r1 && (q1.size() > 0);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
         if (sel) q1.push_back(d);
         else     q0.push_back(d);
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i    = 1'b1;
      valid_i  = 1'b0;
      select_i = 1'b0;
      data_i   = '0;
      ready0_i = 1'b0;
      ready1_i = 1'b0;

      // Reset state before any clock edge.
      #2;
      checkAll("reset", 1'b0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Single push to port 0 appears the next cycle; port 1 stays empty.
      applyStimulus("push0", 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);
      applyStimulus("push0_seen", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("push0_data_direct", data0_o, 32'hA5A5A5A5);
      applyStimulus("drain0", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // Three pushes to port 1: third is refused, then drained in order.
      applyStimulus("p1_a", 1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
      applyStimulus("p1_b", 1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
      applyStimulus("p1_c_refused", 1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
      checkOutput("p1_full_count", SIZE'(count1_o), SIZE'(2));
      applyStimulus("p1_pop1", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      applyStimulus("p1_reoffer", 1'b1, 1'b1, 32'h3, 1'b0, 1'b1);
      applyStimulus("p1_pop3", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      applyStimulus("p1_empty", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);

      // Port 0 full does not block a push to port 1.
      applyStimulus("fill0_a", 1'b1, 1'b0, 32'h10, 1'b0, 1'b0);
      applyStimulus("fill0_b", 1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
      applyStimulus("cross_push1", 1'b1, 1'b1, 32'h20, 1'b0, 1'b0);

      // Port 1 at count 1: push and pop together keep the count at 1.
      applyStimulus("p1_pushpop", 1'b1, 1'b1, 32'h7, 1'b0, 1'b1);
      applyStimulus("p1_after_pushpop", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      checkOutput("p1_pushpop_data", data1_o, 32'h7);

      // Port 0 full with pop and push together: push refused.
      applyStimulus("p0_full_pushpop", 1'b1, 1'b0, 32'h12, 1'b1, 1'b0);
      applyStimulus("p0_after_refuse", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("p0_refuse_count", SIZE'(count0_o), SIZE'(1));

      // Mid-cycle reset with both ports holding data.
      valid_i  = 1'b1;
      select_i = 1'b0;
      data_i   = 32'hDEAD0000;
      ready0_i = 1'b0;
      ready1_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      q0.delete();
      q1.delete();
      checkAll("async_reset", 1'b0);
      @(posedge clk_i);
      #1;
      checkAll("reset_push_ignored", 1'b0);
      rst_i = 1'b0;
      applyStimulus("post_reset", 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
      applyStimulus("post_reset2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      // Random traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom),
                       32'($urandom), 1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demux_1to2_buf.md
DEMUX_1TO2_BUF -- requirements
Module: demux_1to2_buf

Interface
REQ-001 Parameter size, default 32: width of the data word routed through the block.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 data_i  input  size  upstream data word.
REQ-005 valid_i  input  1  upstream word present on data_i.
REQ-006 select_i  input  1  destination of data_i: 0 = port 0, 1 = port 1.
REQ-007 ready_o  output  1  block accepts data_i this cycle.
REQ-008 data0_o  output  size  head word of port 0 buffer.
REQ-009 valid0_o  output  1  port 0 buffer non-empty.
REQ-010 ready0_i  input  1  port 0 consumer takes data0_o this cycle.
REQ-011 data1_o  output  size  head word of port 1 buffer.
REQ-012 valid1_o  output  1  port 1 buffer non-empty.
REQ-013 ready1_i  input  1  port 1 consumer takes data1_o this cycle.
REQ-014 count0_o  output  2  occupancy of port 0 buffer, range 0..2.
REQ-015 count1_o  output  2  occupancy of port 1 buffer, range 0..2.

Function
REQ-016 Each port owns an independent 2-entry in-order buffer; words leave each port in acceptance order.
REQ-017 ready_o = NOT full of the buffer addressed by select_i; purely combinational from select_i and buffer state, with no path from ready0_i/ready1_i.
REQ-018 Accept: valid_i AND ready_o at a rising edge pushes data_i into buffer[select_i].
REQ-019 Latency: an accepted word appears on dataN_o with validN_o=1 in the cycle after acceptance, at the earliest.
REQ-020 Pop: validN_o AND readyN_i at a rising edge removes the head of buffer N.
REQ-021 Simultaneous push and pop on the same non-full buffer: occupancy unchanged; the pushed word queues behind the remaining entries.
REQ-022 Full buffer (count=2): push is refused even when a pop occurs in the same cycle; ready_o rises the cycle after the pop.
REQ-023 Empty buffer: validN_o=0, readyN_i is ignored, and the count is held at 0 (no underflow).
REQ-024 dataN_o is don't-care while validN_o=0 and stable while validN_o=1 AND readyN_i=0.
REQ-025 Traffic to one port never stalls the other: a full port 0 does not block acceptance when select_i=1, and vice versa.
REQ-026 valid_i=0: no push regardless of select_i; ready_o still reflects the addressed buffer.
REQ-027 countN_o is registered and equals the buffer occupancy after each edge.

Reset
REQ-028 rst_i=1 immediately, without waiting for a clock edge, empties both buffers: valid0_o=valid1_o=0, count0_o=count1_o=0, read/write pointers=0.
REQ-029 Reset mid-operation discards buffered words; no word accepted before reset is emitted after it.
REQ-030 While rst_i=1, ready_o=1 (buffers empty); pushes are ignored until rst_i deasserts.
REQ-031 Data storage registers need no reset; only valid, count and pointer state is reset.

Structure
REQ-032 No shared package; buffer depth 2 is a localparam inside the sub-module; the only external parameter is size.
REQ-033 The 2-entry buffer is one sub-module, fifo_2entry (parameter size; ports clk_i, rst_i, push, pop, din, dout, count, full, empty), instantiated twice.
REQ-034 The top level contains only the select decode, the ready_o multiplexer and the port wiring.

Verification
REQ-035 Push 0xA5A5A5A5 (select_i=0) with ready0_i=0 -> next cycle valid0_o=1, data0_o=0xA5A5A5A5, count0_o=1; port 1 stays valid1_o=0.
REQ-036 Three back-to-back pushes to port 1 (0x1, 0x2, 0x3) with ready1_i=0 -> first two accepted, ready_o=0 on the third, count1_o=2; raising ready1_i yields 0x1, 0x2, then 0x3 after it is re-offered.
REQ-037 Port 0 full, valid_i=1, select_i=1 -> ready_o=1 and the word is accepted into port 1.
REQ-038 Port 1 at count=1 with simultaneous push 0x7 and pop -> count1_o stays 1 and data1_o=0x7 next cycle.
REQ-039 Port 0 full, then pop and push in the same cycle -> push refused, count0_o=1, ready_o=1 the following cycle.
REQ-040 Both ports holding data, rst_i asserted mid-cycle -> valid0_o=valid1_o=0 and counts 0 before the next edge; no pre-reset word appears after release.
